// File: rtl/id_ctrl_pkg.sv
// Shared types and sizing for the decode-stage issue controller.
// Register indices, scoreboard width and branch FSM states.
package id_ctrl_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BR_WAIT,
        FLUSH
    } br_state_t;

    function automatic logic [NUM_REGS-1:0] onehot(
        input logic [REG_IDX_W-1:0] idx
    );
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard with same-cycle writeback bypass.
// Flags writebacks that target a register with no pending producer.
module reg_scoreboard
    import id_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_set,
    input  logic [REG_IDX_W-1:0] i_set_idx,
    input  logic                 i_clr,
    input  logic [REG_IDX_W-1:0] i_clr_idx,
    output logic [NUM_REGS-1:0]  o_busy,
    output logic [NUM_REGS-1:0]  o_eff_busy,
    output logic                 o_clr_err
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_clr_vec;

    assign w_set_vec = (i_set && i_set_idx != '0) ? onehot(i_set_idx) : '0;
    assign w_clr_vec = i_clr ? onehot(i_clr_idx) : '0;

    assign o_eff_busy = r_busy & ~w_clr_vec;
    assign o_clr_err  = i_clr && (i_clr_idx != '0) && !r_busy[i_clr_idx];
    assign o_busy     = r_busy;

    // OR-ing the set after the clear lets a new producer win over a retiring one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= o_eff_busy | w_set_vec;
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: RAW/WAW stall via scoreboard,
// branch hold/flush sequencing, stall counter and sticky error flag.
module id_issue_ctrl
    import id_ctrl_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int BR_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 uses_rs1,
    input  logic                 uses_rs2,
    input  logic                 reg_write,
    input  logic                 branch,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 br_resolve,
    input  logic                 br_taken,
    output logic                 issue,
    output logic                 stall,
    output logic                 pc_hold,
    output logic                 flush,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic [CNT_W-1:0]     stall_count,
    output logic                 sb_err
);

    localparam int TO_W = $clog2(BR_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BR_TIMEOUT);

    br_state_t           r_state;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_pc_hold;
    logic                r_flush;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                r_sb_err;

    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_eff_busy;
    logic                w_clr_err;
    logic                w_hz;
    logic                w_issue;
    logic                w_stall;
    logic [TO_W-1:0]     w_to_next;
    logic                w_to_hit;
    logic                w_br_err;

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (reset),
        .i_set      (w_issue & reg_write),
        .i_set_idx  (rd),
        .i_clr      (wb_valid),
        .i_clr_idx  (wb_rd),
        .o_busy     (w_busy),
        .o_eff_busy (w_eff_busy),
        .o_clr_err  (w_clr_err)
    );

    assign w_hz = (uses_rs1  && rs1 != '0 && w_eff_busy[rs1])
                | (uses_rs2  && rs2 != '0 && w_eff_busy[rs2])
                | (reg_write && rd  != '0 && w_eff_busy[rd]);

    // Gating with reset keeps the handshakes quiet while reset is held
    assign w_issue = reset && id_valid && !w_hz && (r_state == IDLE);
    assign w_stall = reset && id_valid && !w_issue;

    assign w_to_next = r_to_cnt + TO_W'(1);
    assign w_to_hit  = (r_state == BR_WAIT) && !br_resolve
                    && (w_to_next == TO_MAX);
    assign w_br_err  = br_resolve && (r_state != BR_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_to_cnt  <= '0;
            r_pc_hold <= 1'b0;
            r_flush   <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_issue && branch) begin
                        r_state   <= BR_WAIT;
                        r_to_cnt  <= '0;
                        r_pc_hold <= 1'b1;
                    end
                end
                BR_WAIT: begin
                    if (br_resolve && br_taken) begin
                        r_state <= FLUSH;
                        r_flush <= 1'b1;
                    end else if (br_resolve || w_to_hit) begin
                        r_state   <= IDLE;
                        r_pc_hold <= 1'b0;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                FLUSH: begin
                    r_state   <= IDLE;
                    r_pc_hold <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_pc_hold <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_sb_err    <= 1'b0;
        end else begin
            if (w_stall && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_clr_err || w_to_hit || w_br_err) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign issue       = w_issue;
    assign stall       = w_stall;
    assign pc_hold     = r_pc_hold;
    assign flush       = r_flush;
    assign busy_mask   = w_busy;
    assign stall_count = r_stall_cnt;
    assign sb_err      = r_sb_err;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: cycle-level reference model plus
// directed scenarios with hand-derived expected values.
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rd = '0;
    logic        uses_rs1 = 1'b0;
    logic        uses_rs2 = 1'b0;
    logic        reg_write = 1'b0;
    logic        branch = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        br_resolve = 1'b0;
    logic        br_taken = 1'b0;
    logic        issue;
    logic        stall;
    logic        pc_hold;
    logic        flush;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;
    logic        sb_err;

    id_issue_ctrl #(.CNT_W(16), .BR_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .reg_write(reg_write), .branch(branch),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .br_resolve(br_resolve), .br_taken(br_taken),
        .issue(issue), .stall(stall), .pc_hold(pc_hold),
        .flush(flush), .busy_mask(busy_mask),
        .stall_count(stall_count), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @%0t: got %0h expected %0h",
                         nm, $time, act, exp);
        end
    endtask

    // Reference model: 0=idle, 1=waiting on branch, 2=flushing
    bit m_busy [32];
    int m_st = 0;
    int m_wait = 0;
    int m_stalls = 0;
    bit m_err = 0;

    function automatic bit m_pending(input int r);
        return m_busy[r] && !(wb_valid && int'(wb_rd) == r);
    endfunction

    function automatic bit m_hazard();
        bit h;
        h = 0;
        if (uses_rs1 && rs1 != 0 && m_pending(int'(rs1))) h = 1;
        if (uses_rs2 && rs2 != 0 && m_pending(int'(rs2))) h = 1;
        if (reg_write && rd != 0 && m_pending(int'(rd))) h = 1;
        return h;
    endfunction

    function automatic bit m_issue();
        return reset && id_valid && !m_hazard() && m_st == 0;
    endfunction

    function automatic bit m_stall();
        return reset && id_valid && !m_issue();
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_busy[i] <= 0;
            m_st <= 0;
            m_wait <= 0;
            m_stalls <= 0;
            m_err <= 0;
        end else begin
            if (wb_valid && wb_rd != 0) begin
                if (!m_busy[wb_rd]) m_err <= 1;
                m_busy[wb_rd] <= 0;
            end
            if (m_issue() && reg_write && rd != 0) m_busy[rd] <= 1;
            if (m_stall() && m_stalls < 65535) m_stalls <= m_stalls + 1;
            if (br_resolve && m_st != 1) m_err <= 1;
            if (m_st == 0) begin
                if (m_issue() && branch) begin
                    m_st <= 1;
                    m_wait <= 0;
                end
            end else if (m_st == 1) begin
                if (br_resolve) begin
                    m_st <= br_taken ? 2 : 0;
                end else if (m_wait + 1 == 15) begin
                    m_st <= 0;
                    m_err <= 1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else begin
                m_st <= 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] eb;
        for (int i = 0; i < 32; i++) eb[i] = m_busy[i];
        chk("issue", 64'(issue), 64'(m_issue()));
        chk("stall", 64'(stall), 64'(m_stall()));
        chk("pc_hold", 64'(pc_hold), 64'(reset && m_st != 0));
        chk("flush", 64'(flush), 64'(reset && m_st == 2));
        chk("busy_mask", 64'(busy_mask), 64'(eb));
        chk("stall_count", 64'(stall_count), 64'(m_stalls));
        chk("sb_err", 64'(sb_err), 64'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
        uses_rs1 = 0; uses_rs2 = 0; reg_write = 0; branch = 0;
        wb_valid = 0; wb_rd = 0; br_resolve = 0; br_taken = 0;
    endtask

    task automatic do_reset();
        tick();
        reset = 0;
        clr();
        tick();
        reset = 1;
    endtask

    initial begin
        clr();
        id_valid = 1;
        tick();
        tick();
        @(negedge clk);
        chk("L rst issue", 64'(issue), 64'(0));
        chk("L rst busy", 64'(busy_mask), 64'(0));
        chk("L rst cnt", 64'(stall_count), 64'(0));
        tick();
        reset = 1;
        clr();

        tick();
        id_valid = 1; rd = 5; reg_write = 1;
        @(negedge clk);
        chk("L issue rd5", 64'(issue), 64'(1));
        tick();
        clr(); id_valid = 1; uses_rs1 = 1; rs1 = 5;
        @(negedge clk);
        chk("L busy 0x20", 64'(busy_mask), 64'h20);
        chk("L raw stall", 64'(stall), 64'(1));
        tick();
        tick();
        @(negedge clk);
        chk("L stall cnt 2", 64'(stall_count), 64'(2));
        tick();
        wb_valid = 1; wb_rd = 5;
        @(negedge clk);
        chk("L wb bypass", 64'(issue), 64'(1));
        tick();
        clr();
        @(negedge clk);
        chk("L busy clr5", 64'(busy_mask), 64'(0));
        chk("L stall cnt 3", 64'(stall_count), 64'(3));

        tick();
        id_valid = 1; rd = 7; reg_write = 1;
        tick();
        wb_valid = 1; wb_rd = 7;
        @(negedge clk);
        chk("L waw bypass", 64'(issue), 64'(1));
        tick();
        clr();
        @(negedge clk);
        chk("L set wins", 64'(busy_mask), 64'h80);
        tick();
        wb_valid = 1; wb_rd = 7;
        tick();
        clr(); id_valid = 1; rd = 0; reg_write = 1;
        tick();
        clr();
        @(negedge clk);
        chk("L rd0", 64'(busy_mask), 64'(0));
        chk("L no err", 64'(sb_err), 64'(0));

        tick();
        id_valid = 1; branch = 1;
        tick();
        clr(); id_valid = 1;
        @(negedge clk);
        chk("L br hold", 64'(pc_hold), 64'(1));
        chk("L br noiss", 64'(issue), 64'(0));
        tick();
        tick();
        tick();
        br_resolve = 1; br_taken = 1;
        tick();
        br_resolve = 0; br_taken = 0;
        @(negedge clk);
        chk("L flush", 64'(flush), 64'(1));
        tick();
        @(negedge clk);
        chk("L flush end", 64'(flush), 64'(0));
        chk("L resume", 64'(issue), 64'(1));

        tick();
        clr(); id_valid = 1; branch = 1;
        tick();
        clr(); br_resolve = 1;
        tick();
        clr(); id_valid = 1;
        @(negedge clk);
        chk("L nt noflush", 64'(flush), 64'(0));
        chk("L nt resume", 64'(issue), 64'(1));

        tick();
        clr(); id_valid = 1; branch = 1;
        tick();
        clr();
        repeat (14) tick();
        @(negedge clk);
        chk("L to still", 64'(pc_hold), 64'(1));
        chk("L to noerr", 64'(sb_err), 64'(0));
        tick();
        @(negedge clk);
        chk("L to exit", 64'(pc_hold), 64'(0));
        chk("L to err", 64'(sb_err), 64'(1));

        do_reset();
        wb_valid = 1; wb_rd = 9;
        tick();
        clr();
        @(negedge clk);
        chk("L wb idle", 64'(sb_err), 64'(1));

        do_reset();
        br_resolve = 1;
        tick();
        clr();
        @(negedge clk);
        chk("L stray res", 64'(sb_err), 64'(1));

        do_reset();
        for (int i = 1; i < 16; i++) begin
            clr(); id_valid = 1; rd = 5'(i); reg_write = 1;
            tick();
        end
        clr(); id_valid = 1; branch = 1;
        tick();
        clr(); id_valid = 1;
        @(negedge clk);
        chk("L busy fffe", 64'(busy_mask), 64'hFFFE);
        chk("L mid hold", 64'(pc_hold), 64'(1));
        tick();
        reset = 0;
        #1;
        chk("L ar busy", 64'(busy_mask), 64'(0));
        chk("L ar hold", 64'(pc_hold), 64'(0));
        chk("L ar stall", 64'(stall), 64'(0));
        chk("L ar flush", 64'(flush), 64'(0));
        tick();
        reset = 1;
        clr();

        tick();
        id_valid = 1; rd = 3; reg_write = 1;
        tick();
        clr(); id_valid = 1; uses_rs1 = 1; rs1 = 3;
        repeat (65539) tick();
        @(negedge clk);
        chk("L sat", 64'(stall_count), 64'hFFFF);
        tick();
        clr();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
